// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM ch1 arbiter: channel ids, FSM states, the request
// record and the fixed-priority winner selection.
package sdram_arb_pkg;

    // Address width carried by the request record; the arbiter's ADDR_W must match.
    localparam int ARB_ADDR_W = 27;

    typedef enum logic [1:0] {
        CH_DL   = 2'd0,
        CH_CORE = 2'd1,
        CH_SS   = 2'd2
    } chan_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic                  rnw;
        logic [ARB_ADDR_W-1:0] addr;
        logic [3:0]            be;
        logic [31:0]           din;
    } req_t;

    // Download always wins; savestate overrides the core once the burst budget is used up.
    function automatic chan_e pick_winner(input logic dl_p, input logic core_p,
                                          input logic ss_p, input logic burst_full);
        chan_e w;
        if (dl_p) begin
            w = CH_DL;
        end else if (core_p && !(ss_p && burst_full)) begin
            w = CH_CORE;
        end else if (ss_p) begin
            w = CH_SS;
        end else begin
            w = CH_CORE;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_arb_chan.sv
// One requester slot: captures a request into a holding register, tracks the
// pending flag until completion and flags requests that arrive while busy.
module sdram_arb_chan
    import sdram_arb_pkg::*;
(
    input  logic clk1x,
    input  logic reset_n,
    input  logic req,
    input  req_t req_data,
    input  logic clr,
    output logic pending_r,
    output req_t hold_r,
    output logic overflow_s
);

    logic busy_s;
    logic accept_s;

    // A request landing on the completion edge is a new request, not an overflow.
    always_comb begin
        busy_s     = pending_r && !clr;
        accept_s   = req && !busy_s;
        overflow_s = req && busy_s;
    end

    // Pending flag and holding register.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= 1'b0;
            hold_r    <= '0;
        end else if (accept_s) begin
            pending_r <= 1'b1;
            hold_r    <= req_data;
        end else if (clr) begin
            pending_r <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares SDRAM ch1 between cart download, the core and the savestate engine:
// one access in flight at a time, completion routed back to the winner.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_BURST = 8
)(
    input  logic              clk1x,
    input  logic              reset_n,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [31:0]       dl_din,
    output logic              dl_done,
    input  logic              core_req,
    input  logic              core_rnw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [3:0]        core_be,
    input  logic [31:0]       core_din,
    output logic [31:0]       core_dout,
    output logic              core_done,
    input  logic              ss_req,
    input  logic              ss_rnw,
    input  logic [ADDR_W-1:0] ss_addr,
    input  logic [3:0]        ss_be,
    input  logic [31:0]       ss_din,
    output logic [31:0]       ss_dout,
    output logic              ss_done,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    input  logic              mem_ready,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int TMO_W   = $clog2(TIMEOUT);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    state_e              state_r, state_s;
    chan_e               winner_r, win_s;
    logic [TMO_W-1:0]    tmo_r;
    logic [BURST_W-1:0]  burst_r;
    logic                grant_s, finish_s, abort_s;
    logic                clr_dl_s, clr_core_s, clr_ss_s;
    logic                dl_pend_r, core_pend_r, ss_pend_r;
    logic                dl_ovf_s, core_ovf_s, ss_ovf_s;
    req_t                dl_rec_s, core_rec_s, ss_rec_s;
    req_t                dl_hold_r, core_hold_r, ss_hold_r, sel_s;
    logic [31:0]         rdata_s;

    assign dl_rec_s   = '{rnw: 1'b0, addr: dl_addr, be: 4'hF, din: dl_din};
    assign core_rec_s = '{rnw: core_rnw, addr: core_addr, be: core_be, din: core_din};
    assign ss_rec_s   = '{rnw: ss_rnw, addr: ss_addr, be: ss_be, din: ss_din};

    sdram_arb_chan u_dl (
        .clk1x(clk1x), .reset_n(reset_n), .req(dl_req), .req_data(dl_rec_s),
        .clr(clr_dl_s), .pending_r(dl_pend_r), .hold_r(dl_hold_r), .overflow_s(dl_ovf_s)
    );

    sdram_arb_chan u_core (
        .clk1x(clk1x), .reset_n(reset_n), .req(core_req), .req_data(core_rec_s),
        .clr(clr_core_s), .pending_r(core_pend_r), .hold_r(core_hold_r), .overflow_s(core_ovf_s)
    );

    sdram_arb_chan u_ss (
        .clk1x(clk1x), .reset_n(reset_n), .req(ss_req), .req_data(ss_rec_s),
        .clr(clr_ss_s), .pending_r(ss_pend_r), .hold_r(ss_hold_r), .overflow_s(ss_ovf_s)
    );

    // Next-state, grant and completion decode.
    always_comb begin
        state_s  = state_r;
        win_s    = winner_r;
        grant_s  = 1'b0;
        finish_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dl_pend_r || core_pend_r || ss_pend_r) begin
                    grant_s = 1'b1;
                    win_s   = pick_winner(dl_pend_r, core_pend_r, ss_pend_r,
                                          burst_r == BURST_MAX);
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else if (tmo_r == TMO_LAST) begin
                    finish_s = 1'b1;
                    abort_s  = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase

        clr_dl_s   = finish_s && (winner_r == CH_DL);
        clr_core_s = finish_s && (winner_r == CH_CORE);
        clr_ss_s   = finish_s && (winner_r == CH_SS);
        rdata_s    = abort_s ? 32'h0000_0000 : mem_dout;

        case (win_s)
            CH_DL:   sel_s = dl_hold_r;
            CH_CORE: sel_s = core_hold_r;
            CH_SS:   sel_s = ss_hold_r;
            default: sel_s = core_hold_r;
        endcase
    end

    // FSM state, current winner and access timeout counter.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            winner_r <= CH_DL;
            tmo_r    <= '0;
        end else begin
            state_r  <= state_s;
            winner_r <= win_s;
            if (grant_s) begin
                tmo_r <= '0;
            end else if (state_r == WAIT) begin
                tmo_r <= tmo_r + 1'b1;
            end
        end
    end

    // Core grants taken while savestate waits; savestate gets a slot when it saturates.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            burst_r <= '0;
        end else if (!ss_pend_r || (grant_s && win_s == CH_SS)) begin
            burst_r <= '0;
        end else if (grant_s && win_s == CH_CORE) begin
            burst_r <= burst_r + 1'b1;
        end
    end

    // SDRAM command outputs, held until the next grant.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            mem_req  <= 1'b0;
            mem_rnw  <= 1'b0;
            mem_addr <= '0;
            mem_be   <= 4'h0;
            mem_din  <= 32'h0000_0000;
        end else begin
            mem_req <= grant_s;
            if (grant_s) begin
                mem_rnw  <= sel_s.rnw;
                mem_addr <= sel_s.addr;
                mem_be   <= sel_s.be;
                mem_din  <= sel_s.din;
            end
        end
    end

    // Completion pulses and read data; a write completion leaves dout untouched.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            dl_done   <= 1'b0;
            core_done <= 1'b0;
            ss_done   <= 1'b0;
            core_dout <= 32'h0000_0000;
            ss_dout   <= 32'h0000_0000;
        end else begin
            dl_done   <= clr_dl_s;
            core_done <= clr_core_s;
            ss_done   <= clr_ss_s;
            if (clr_core_s && mem_rnw) begin
                core_dout <= rdata_s;
            end
            if (clr_ss_s && mem_rnw) begin
                ss_dout <= rdata_s;
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_overflow <= err_overflow | dl_ovf_s | core_ovf_s | ss_ovf_s;
            err_timeout  <= err_timeout | abort_s;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: latency, priority, burst fairness,
// overflow, timeout and mid-access reset.
module tb_sdram_arbiter;

    localparam int AW = 27;

    logic          clk1x = 1'b0;
    logic          reset_n;
    logic          dl_req, core_req, core_rnw, ss_req, ss_rnw, mem_ready;
    logic [AW-1:0] dl_addr, core_addr, ss_addr;
    logic [31:0]   dl_din, core_din, ss_din, mem_dout;
    logic [3:0]    core_be, ss_be;
    logic          dl_done, core_done, ss_done, mem_req, mem_rnw, err_overflow, err_timeout;
    logic [31:0]   core_dout, ss_dout, mem_din;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int dl_done_cnt = 0, core_done_cnt = 0, ss_done_cnt = 0, core_done_cyc = 0;
    logic [AW-1:0] addr_log[$];
    logic          rnw_log[$];
    logic [3:0]    be_log[$];
    logic [31:0]   din_log[$];

    sdram_arbiter dut (
        .clk1x(clk1x), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_done(dl_done),
        .core_req(core_req), .core_rnw(core_rnw), .core_addr(core_addr), .core_be(core_be),
        .core_din(core_din), .core_dout(core_dout), .core_done(core_done),
        .ss_req(ss_req), .ss_rnw(ss_rnw), .ss_addr(ss_addr), .ss_be(ss_be),
        .ss_din(ss_din), .ss_dout(ss_dout), .ss_done(ss_done),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready),
        .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk1x = ~clk1x;

    always @(posedge clk1x) cyc <= cyc + 1;

    always @(negedge clk1x) begin
        if (dl_done) dl_done_cnt <= dl_done_cnt + 1;
        if (ss_done) ss_done_cnt <= ss_done_cnt + 1;
        if (core_done) begin
            core_done_cnt <= core_done_cnt + 1;
            core_done_cyc <= cyc;
        end
        if (mem_req) begin
            addr_log.push_back(mem_addr);
            rnw_log.push_back(mem_rnw);
            be_log.push_back(mem_be);
            din_log.push_back(mem_din);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk1x);
    endtask

    task automatic wait_mem_req(input string tag);
        int t = 0;
        while (mem_req !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        check(tag, mem_req, 1'b1);
    endtask

    // Waits for the next mem_req, then answers dly cycles later.
    task automatic serve(input logic [31:0] data, input int dly, input logic core_again);
        wait_mem_req("serve_wait");
        tick(dly);
        mem_ready = 1'b1;
        mem_dout  = data;
        if (core_again) core_req = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        mem_dout  = 32'h0;
        core_req  = 1'b0;
    endtask

    task automatic pulse_ready(input logic [31:0] data);
        mem_ready = 1'b1;
        mem_dout  = data;
        tick(1);
        mem_ready = 1'b0;
        mem_dout  = 32'h0;
    endtask

    initial begin
        int c0, base, n, t, dcnt;
        reset_n = 1'b0;
        dl_req = 1'b0; core_req = 1'b0; ss_req = 1'b0; mem_ready = 1'b0;
        core_rnw = 1'b1; ss_rnw = 1'b1;
        dl_addr = '0; core_addr = '0; ss_addr = '0;
        dl_din = 32'h0; core_din = 32'h0; ss_din = 32'h0; mem_dout = 32'h0;
        core_be = 4'hF; ss_be = 4'hF;
        tick(3);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 27'h0);
        check("rst_core_dout", core_dout, 32'h0);
        check("rst_err_ovf", err_overflow, 1'b0);
        check("rst_err_tmo", err_timeout, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // single core read with a 5-cycle memory delay
        core_rnw = 1'b1; core_addr = 27'h0800010; core_be = 4'hF;
        c0 = cyc;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        serve(32'h12345678, 5, 1'b0);
        tick(2);
        check("t1_done_cnt", core_done_cnt, 1);
        check("t1_dout", core_dout, 32'h12345678);
        check("t1_latency", core_done_cyc - c0, 8);
        check("t1_addr", addr_log[0], 27'h0800010);
        check("t1_rnw", rnw_log[0], 1'b1);

        // simultaneous requests: dl, then core, then ss
        dl_addr = 27'h0000100; dl_din = 32'hA5A5_0001;
        core_rnw = 1'b0; core_addr = 27'h0000200; core_be = 4'h3; core_din = 32'hCAFE_0002;
        ss_rnw = 1'b1; ss_addr = 27'h0000300;
        dl_req = 1'b1; core_req = 1'b1; ss_req = 1'b1;
        tick(1);
        dl_req = 1'b0; core_req = 1'b0; ss_req = 1'b0;
        serve(32'h1111_1111, 1, 1'b0);
        serve(32'h2222_2222, 1, 1'b0);
        serve(32'h3333_3333, 2, 1'b0);
        tick(2);
        check("t2_log_size", addr_log.size(), 4);
        check("t2_addr_dl", addr_log[1], 27'h0000100);
        check("t2_rnw_dl", rnw_log[1], 1'b0);
        check("t2_be_dl", be_log[1], 4'hF);
        check("t2_din_dl", din_log[1], 32'hA5A5_0001);
        check("t2_addr_core", addr_log[2], 27'h0000200);
        check("t2_be_core", be_log[2], 4'h3);
        check("t2_din_core", din_log[2], 32'hCAFE_0002);
        check("t2_addr_ss", addr_log[3], 27'h0000300);
        check("t2_dl_done", dl_done_cnt, 1);
        check("t2_core_done", core_done_cnt, 2);
        check("t2_ss_done", ss_done_cnt, 1);
        check("t2_core_dout_kept", core_dout, 32'h12345678);
        check("t2_ss_dout", ss_dout, 32'h3333_3333);

        // burst fairness: core keeps re-requesting on each completion edge
        base = addr_log.size();
        core_rnw = 1'b1; core_addr = 27'h0000400; core_be = 4'hF;
        ss_rnw = 1'b1; ss_addr = 27'h0000500;
        core_req = 1'b1; ss_req = 1'b1;
        tick(1);
        core_req = 1'b0; ss_req = 1'b0;
        for (int i = 0; i < 8; i++) serve(32'h4000_0000 + i, 0, 1'b1);
        serve(32'h5555_5555, 0, 1'b0);
        serve(32'h4444_4444, 0, 1'b0);
        tick(3);
        check("t3_log_size", addr_log.size(), base + 10);
        for (int i = 0; i < 8; i++) check("t3_core_grant", addr_log[base + i], 27'h0000400);
        check("t3_ss_grant", addr_log[base + 8], 27'h0000500);
        check("t3_core_resume", addr_log[base + 9], 27'h0000400);
        check("t3_no_ovf", err_overflow, 1'b0);
        check("t3_ss_dout", ss_dout, 32'h5555_5555);
        check("t3_core_dout", core_dout, 32'h4444_4444);

        // overflow: second core_req while the first is in WAIT
        base = addr_log.size();
        dcnt = core_done_cnt;
        core_rnw = 1'b0; core_addr = 27'h0000600; core_din = 32'h6666_0006;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        tick(1);
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        pulse_ready(32'h0);
        tick(4);
        check("t4_err_ovf", err_overflow, 1'b1);
        check("t4_one_grant", addr_log.size(), base + 1);
        check("t4_addr", addr_log[base], 27'h0000600);
        check("t4_one_done", core_done_cnt, dcnt + 1);

        // timeout: no mem_ready at all
        core_rnw = 1'b1; core_addr = 27'h0000700;
        core_req = 1'b1;
        tick(1);
        core_req = 1'b0;
        wait_mem_req("t5_grant");
        n = 0;
        while (core_done !== 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        check("t5_latency", n, 4096);
        check("t5_dout_zero", core_dout, 32'h0);
        check("t5_err_tmo", err_timeout, 1'b1);
        tick(3);
        base = addr_log.size();
        dcnt = core_done_cnt;
        pulse_ready(32'hDEAD_BEEF);
        tick(3);
        check("t5_stray_no_done", core_done_cnt, dcnt);
        check("t5_stray_no_grant", addr_log.size(), base);
        check("t5_dout_held", core_dout, 32'h0);

        // reset during WAIT, then a fresh savestate read
        ss_rnw = 1'b1; ss_addr = 27'h0000800;
        ss_req = 1'b1;
        tick(1);
        ss_req = 1'b0;
        wait_mem_req("t6_grant");
        tick(2);
        reset_n = 1'b0;
        #1;
        check("t6_rst_mem_addr", mem_addr, 27'h0);
        check("t6_rst_ss_dout", ss_dout, 32'h0);
        check("t6_rst_err_ovf", err_overflow, 1'b0);
        check("t6_rst_err_tmo", err_timeout, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        base = addr_log.size();
        dcnt = ss_done_cnt;
        pulse_ready(32'hBAD0_0BAD);
        tick(3);
        check("t6_late_no_done", ss_done_cnt, dcnt);
        check("t6_no_grant", addr_log.size(), base);
        ss_addr = 27'h0000900;
        ss_req = 1'b1;
        tick(1);
        ss_req = 1'b0;
        serve(32'h9999_0009, 3, 1'b0);
        tick(2);
        check("t6_ss_done", ss_done_cnt, dcnt + 1);
        check("t6_ss_dout", ss_dout, 32'h9999_0009);
        check("t6_ss_addr", addr_log[base], 27'h0000900);

        t = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
